// File: rtl/sipo_comma_align.sv
// sipo_comma_align: receive-side deserializer with K28.5 comma alignment for an 8b/10b lane.
//
// Serial bits arrive LSB of each symbol first. A 10-bit sliding window is compared against
// both disparities of K28.5. In hunt, the first comma fixes the symbol boundary. While
// locked, a symbol is emitted every tenth enabled bit. Commas at other positions pulse
// align_err_o. LOSS_THRESH consecutive misaligned commas move the boundary onto the latest
// one. An aligned comma clears that run.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous reset, active-high
//   en_i          bit enable; sin_i is sampled only when high
//   sin_i         serial data, LSB of each symbol first
//   pout_o        aligned 10-bit symbol, bit0 = first received bit
//   pvalid_o      one-cycle pulse: pout_o holds a new symbol
//   is_comma_o    qualifies pvalid_o: symbol is COMMA_N or COMMA_P
//   locked_o      symbol alignment established
//   align_err_o   one-cycle pulse: comma seen off the boundary while locked
//
// Optional (`define SIPO_ALIGN_STATS_EN):
//   comma_cnt_o   saturating count of emitted comma symbols
//   realign_cnt_o saturating count of threshold re-alignments
module sipo_comma_align #(
    parameter logic [9:0]  COMMA_N     = 10'h17C,
    parameter logic [9:0]  COMMA_P     = 10'h283,
    parameter int unsigned LOSS_THRESH = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       sin_i,
    output logic [9:0] pout_o,
    output logic       pvalid_o,
    output logic       is_comma_o,
    output logic       locked_o,
    output logic       align_err_o
`ifdef SIPO_ALIGN_STATS_EN
    ,
    output logic [15:0] comma_cnt_o,
    output logic [7:0]  realign_cnt_o
`endif
);

    typedef enum logic [0:0] {StHunt, StLocked} state_e;

    localparam logic [2:0] LossThresh = LOSS_THRESH[2:0];

    state_e     state_q, state_d;
    logic [9:0] win_q, win_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] mcnt_q, mcnt_d;
    logic [9:0] pout_q, pout_d;
    logic       pvalid_q, pvalid_d;
    logic       is_comma_q, is_comma_d;
    logic       align_err_q, align_err_d;
    logic       realign;

    logic [9:0] nxt;
    logic       nxt_comma;

    // Window as it will look after this bit is shifted in; oldest bit lands in bit0.
    assign nxt       = {sin_i, win_q[9:1]};
    assign nxt_comma = (nxt == COMMA_N) || (nxt == COMMA_P);

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        cnt_d       = cnt_q;
        mcnt_d      = mcnt_q;
        pout_d      = pout_q;
        pvalid_d    = 1'b0;
        is_comma_d  = 1'b0;
        align_err_d = 1'b0;
        realign     = 1'b0;

        if (en_i) begin
            win_d = nxt;
            unique case (state_q)
                StHunt: begin
                    if (nxt_comma) begin
                        pout_d     = nxt;
                        pvalid_d   = 1'b1;
                        is_comma_d = 1'b1;
                        cnt_d      = 4'd0;
                        mcnt_d     = 3'd0;
                        state_d    = StLocked;
                    end
                end
                StLocked: begin
                    if (cnt_q == 4'd9) begin
                        pout_d     = nxt;
                        pvalid_d   = 1'b1;
                        is_comma_d = nxt_comma;
                        cnt_d      = 4'd0;
                        if (nxt_comma) begin
                            mcnt_d = 3'd0;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                        if (nxt_comma) begin
                            align_err_d = 1'b1;
                            if (mcnt_q + 3'd1 == LossThresh) begin
                                // Too many commas off the boundary: adopt this one.
                                pout_d     = nxt;
                                pvalid_d   = 1'b1;
                                is_comma_d = 1'b1;
                                cnt_d      = 4'd0;
                                mcnt_d     = 3'd0;
                                realign    = 1'b1;
                            end else begin
                                mcnt_d = mcnt_q + 3'd1;
                            end
                        end
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StHunt;
            win_q       <= 10'd0;
            cnt_q       <= 4'd0;
            mcnt_q      <= 3'd0;
            pout_q      <= 10'd0;
            pvalid_q    <= 1'b0;
            is_comma_q  <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            cnt_q       <= cnt_d;
            mcnt_q      <= mcnt_d;
            pout_q      <= pout_d;
            pvalid_q    <= pvalid_d;
            is_comma_q  <= is_comma_d;
            align_err_q <= align_err_d;
        end
    end

    assign pout_o      = pout_q;
    assign pvalid_o    = pvalid_q;
    assign is_comma_o  = is_comma_q;
    assign locked_o    = (state_q == StLocked);
    assign align_err_o = align_err_q;

`ifdef SIPO_ALIGN_STATS_EN
    logic [15:0] comma_cnt_q;
    logic [7:0]  realign_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            comma_cnt_q   <= 16'd0;
            realign_cnt_q <= 8'd0;
        end else begin
            if (pvalid_d && is_comma_d && (comma_cnt_q != 16'hFFFF)) begin
                comma_cnt_q <= comma_cnt_q + 16'd1;
            end
            if (realign && (realign_cnt_q != 8'hFF)) begin
                realign_cnt_q <= realign_cnt_q + 8'd1;
            end
        end
    end

    assign comma_cnt_o   = comma_cnt_q;
    assign realign_cnt_o = realign_cnt_q;
`else
    logic unused_realign;
    assign unused_realign = realign;
`endif

endmodule

// File: doc/sipo_comma_align.md
Name: sipo_comma_align

Overview:
- Receive-side deserializer for the PCIe 8b/10b serial lane.
- Shifts in a serial bitstream, LSB of each symbol first, matching the lane's PISO transmitter.
- Finds 10-bit symbol boundaries by detecting the K28.5 comma and presents aligned 10-bit symbols with a valid strobe to the downstream 10b/8b decoder.
- Tracks alignment loss and re-aligns on repeated misaligned commas.

Parameters:
- COMMA_N, 10'h17C, K28.5 RD- in bit order {j,h,g,f,i,e,d,c,b,a}, with a at bit0.
- COMMA_P, 10'h283, K28.5 RD+ (bitwise complement of COMMA_N).
- LOSS_THRESH, 3, number of consecutive misaligned commas (range 1..7) that forces re-alignment.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- en  input  1  bit enable; sin is sampled only on cycles with en=1
- sin  input  1  serial data, LSB of each symbol first
- pout  output  10  aligned parallel symbol, bit0 = first received bit
- pvalid  output  1  one-cycle pulse: pout holds a new symbol
- is_comma  output  1  qualifies pvalid: symbol equals COMMA_N or COMMA_P
- locked  output  1  1 = symbol alignment established
- align_err  output  1  one-cycle pulse: comma seen at a misaligned position while locked

Behaviour:
- Reset (async, rst=1): pout=0, pvalid=0, is_comma=0, locked=0, align_err=0, window=0, bit counter cnt=0, misalign counter mcnt=0, state=HUNT.
- Window: on each en=1 edge, win <= {sin, win[9:1]}. Define nxt = {sin, win[9:1]}; it holds the last 10 bits with the oldest bit in bit0.
- en=0: all state holds; pvalid, align_err and is_comma are 0 on the following cycle.
- Latency: pout, pvalid and is_comma are registered and valid the cycle after the en edge that sampled the symbol's 10th bit.
- HUNT (locked=0):
  - Each en cycle compares nxt against COMMA_N and COMMA_P.
  - On a match: pout<=nxt, pvalid=1, is_comma=1, cnt<=0, mcnt<=0, state<=LOCKED, locked=1 from the next cycle.
  - No symbols other than the comma are emitted while in HUNT.
- LOCKED: on each en cycle, cnt increments modulo 10.
  - cnt==9 (boundary): pout<=nxt, pvalid=1, is_comma=(nxt is a comma), cnt<=0. An aligned comma clears mcnt.
  - cnt!=9 and nxt is a comma (misaligned): align_err=1 and mcnt<=mcnt+1.
    - If mcnt+1 == LOSS_THRESH: re-align to this comma. pout<=nxt, pvalid=1, is_comma=1, cnt<=0, mcnt<=0; locked stays 1.
    - Otherwise the symbol stream continues on the old alignment.
  - Non-comma symbols never affect mcnt.
- Simultaneous events: only one comparison per cycle, so the boundary and misaligned cases are mutually exclusive.
- Reset mid-symbol: partial window contents are discarded and the block returns to HUNT. No pvalid is emitted until a new comma is found.
- Widths: cnt is 4 bits; mcnt is 3 bits and saturates conceptually at LOSS_THRESH, because it resets when it reaches the threshold.

Optional Feature:
- Macro: SIPO_ALIGN_STATS_EN.
- Defined: adds output ports comma_cnt[15:0] and realign_cnt[7:0], both reset to 0.
  - comma_cnt increments on every pvalid with is_comma=1.
  - realign_cnt increments on each LOSS_THRESH re-alignment.
  - Both saturate at all-ones.
- Not defined: these ports and their counters are absent. All other behaviour is identical.

Test Plan:
- Lock from reset: rst pulse, en=1. Feed 3 random bits, then 10'h17C LSB first, then 10'h2AA. Required: pvalid with pout=10'h17C, is_comma=1, locked=1 one cycle after the 13th bit. Then pvalid with pout=10'h2AA, is_comma=0 exactly 10 en-cycles later.
- RD+ comma and en gaps: after lock, send 10'h283 with en deasserted every other cycle. Required: exactly one pvalid, pout=10'h283, is_comma=1, 20 clk cycles after the symbol start, and no pvalid during en=0 gaps.
- Misalignment recovery, LOSS_THRESH=3: while locked, insert 1 extra bit, then 3 commas. Required: align_err pulses on the first two commas while the old alignment continues. On the third comma: pvalid with pout=10'h17C, and subsequent symbols are aligned to the new boundary.
- Aligned comma clears mcnt: two misaligned commas, then a correctly aligned comma, then two more misaligned commas. Required: 4 align_err pulses and no re-alignment.
- Async reset mid-symbol: assert rst after 5 bits of a symbol. Required: all outputs go 0 immediately, without waiting for a clock edge. No pvalid until a fresh comma is detected.
- With SIPO_ALIGN_STATS_EN: 5 aligned commas plus one forced re-alignment. Required: comma_cnt=6 and realign_cnt=1.
